// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

  typedef logic [0:0] u1;
  typedef logic [1:0] u2;
  typedef logic [2:0] u3;
  typedef logic [5:0] u6;

  // Opcodes (instr[31:26])
  localparam u6 OP_RTYPE = 6'h00;
  localparam u6 OP_J     = 6'h02;
  localparam u6 OP_BEQ   = 6'h04;
  localparam u6 OP_BNE   = 6'h05;
  localparam u6 OP_ADDI  = 6'h08;
  localparam u6 OP_LW    = 6'h23;
  localparam u6 OP_SW    = 6'h2b;

  // R-type funct codes (instr[5:0])
  localparam u6 FN_ADD = 6'h20;
  localparam u6 FN_SUB = 6'h22;
  localparam u6 FN_AND = 6'h24;
  localparam u6 FN_OR  = 6'h25;
  localparam u6 FN_SLT = 6'h2a;

  // ALU control codes
  localparam u3 ALU_AND = 3'b000;
  localparam u3 ALU_OR  = 3'b001;
  localparam u3 ALU_ADD = 3'b010;
  localparam u3 ALU_SUB = 3'b110;
  localparam u3 ALU_SLT = 3'b111;

  // FSM-to-decoder ALU operation class
  localparam u2 ALUOP_ADD   = 2'b00;
  localparam u2 ALUOP_SUB   = 2'b01;
  localparam u2 ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the FSM's aluop class and the R-type funct field to alucontrol.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module multicycle_ctrl_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown funct codes fall back to add so the instruction still completes.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Latency: one state per clock; lw 5, sw/R-type/addi 4, beq/bne/j 3, illegal 2 cycles.
// Backpressure: none; the sequence free-runs, only synchronous reset can abort it.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen
);

  state_t state_q, state_d;
  // bne-ness is captured in DECODE so op may change freely during BRANCH.
  logic   isbne_q, isbne_d;

  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       irwrite_raw, memwrite_raw, regwrite_raw;

  // Next-state logic; op is consulted only in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    isbne_d = isbne_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        isbne_d = SUPPORT_BNE && (op == OP_BNE);
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       state_d = SUPPORT_BNE ? S_BRANCH : S_FETCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      isbne_q <= 1'b0;
    end else begin
      state_q <= state_d;
      isbne_q <= isbne_d;
    end
  end

  // Moore output decode; during reset the FETCH mux selects are shown with writes suppressed.
  always_comb begin
    iord         = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = ALUOP_ADD;
    case (reset ? S_FETCH : state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b01;
        pcwrite     = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        aluop   = ALUOP_SUB;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are gated by reset so an aborted instruction leaves no trace.
  assign irwrite  = irwrite_raw  & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign pcen     = ~reset & (pcwrite | (branch & (zero ^ isbne_q)));

  multicycle_ctrl_alu_dec u_alu_dec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output traces from a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_ctrl;

  localparam bit BNE = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
  } obs_t;

  obs_t dut_obs;
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_ctrl #(.SUPPORT_BNE(BNE)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .pcen       (pcen)
  );

  always #5 clk = ~clk;

  assign dut_obs = {iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
                    alusrcb, pcsrc, alucontrol, pcen};

  // ---------------- reference model ----------------
  function automatic int instr_len(input logic [5:0] o);
    case (o)
      6'h23: return 5;
      6'h2b, 6'h00, 6'h08: return 4;
      6'h04, 6'h02: return 3;
      6'h05: return BNE ? 3 : 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2a: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction; care says whether alucontrol is specified.
  function automatic void expect_cycle(input logic [5:0] o, input logic [5:0] f, input logic z,
                                       input int k, output obs_t e, output bit care);
    e = '0;
    care = 1'b0;
    if (k == 0) begin
      e.irwrite = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1; e.alucontrol = 3'b010; care = 1'b1;
    end else if (k == 1) begin
      e.alusrcb = 2'b11; e.alucontrol = 3'b010; care = 1'b1;
    end else begin
      case (o)
        6'h23, 6'h2b, 6'h08: begin
          if (k == 2) begin
            e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; care = 1'b1;
          end else if (o == 6'h23 && k == 3) e.iord = 1'b1;
          else if (o == 6'h23 && k == 4) begin
            e.regwrite = 1'b1; e.memtoreg = 1'b1;
          end else if (o == 6'h2b) begin
            e.iord = 1'b1; e.memwrite = 1'b1;
          end else e.regwrite = 1'b1;
        end
        6'h00: begin
          if (k == 2) begin
            e.alusrca = 1'b1; e.alucontrol = alu_of_funct(f); care = 1'b1;
          end else begin
            e.regdst = 1'b1; e.regwrite = 1'b1;
          end
        end
        6'h04, 6'h05: begin
          e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alucontrol = 3'b110; care = 1'b1;
          e.pcen = z ^ (o == 6'h05);
        end
        6'h02: begin
          e.pcsrc = 2'b10; e.pcen = 1'b1;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic obs_t reset_obs();
    obs_t e;
    e = '0;
    e.alusrcb = 2'b01;
    e.alucontrol = 3'b010;
    return e;
  endfunction

  function automatic obs_t mask(input obs_t x, input bit care);
    obs_t y;
    y = x;
    if (!care) y.alucontrol = 3'b000;
    return y;
  endfunction

  // Inputs for cycle k: op/funct/zero carry real values only where they matter, noise elsewhere.
  function automatic void stim(input logic [5:0] o, input logic [5:0] f, input logic z, input int k,
                               output logic [5:0] so, output logic [5:0] sf, output logic sz);
    so = (k == 1 || k == 2) ? o : 6'($urandom);
    sf = (k == 2 && o == 6'h00) ? f : 6'($urandom);
    sz = (k == 2 && (o == 6'h04 || o == 6'h05)) ? z : 1'($urandom);
  endfunction

  // One clock: drive just after the edge, sample mid-cycle.
  task automatic tick(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                      output obs_t g);
    @(posedge clk);
    #1;
    reset = r; op = o; funct = f; zero = z;
    #4;
    g = dut_obs;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t g, e;
    e = reset_obs();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), g);
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%h want=%h", i, g, e);
      end
    end
  endtask

  logic [5:0] d_op [10] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h04, 6'h05, 6'h05, 6'h02, 6'h3f, 6'h08};
  logic [5:0] d_fn [10] = '{6'h00, 6'h00, 6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  logic       d_z  [10] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

  task automatic test_directed();
    obs_t g, e;
    bit care;
    logic [5:0] so, sf;
    logic sz;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < instr_len(d_op[i]); k++) begin
        stim(d_op[i], d_fn[i], d_z[i], k, so, sf, sz);
        tick(1'b0, so, sf, sz, g);
        expect_cycle(d_op[i], d_fn[i], d_z[i], k, e, care);
        n_cmp++;
        if (mask(g, care) !== mask(e, care)) begin
          n_bad++;
          $display("FAIL directed op=%h k=%0d got=%h want=%h", d_op[i], k, g, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back_random();
    obs_t g, e;
    bit care;
    logic [5:0] so, sf, o, f;
    logic sz, z;
    logic [5:0] ops [8] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02, 6'h00};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      f = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      z = 1'($urandom);
      for (int k = 0; k < instr_len(o); k++) begin
        stim(o, f, z, k, so, sf, sz);
        tick(1'b0, so, sf, sz, g);
        expect_cycle(o, f, z, k, e, care);
        n_cmp++;
        if (mask(g, care) !== mask(e, care)) begin
          n_bad++;
          $display("FAIL random op=%h fn=%h z=%0d k=%0d got=%h want=%h", o, f, z, k, g, e);
        end
      end
    end
  endtask

  // Abort an sw in MEMWR with reset held for 'hold' cycles, then confirm a clean lw follows.
  task automatic test_reset_mid(input int hold);
    obs_t g, e;
    bit care;
    logic [5:0] so, sf;
    logic sz;
    for (int k = 0; k < 3; k++) begin
      stim(6'h2b, 6'h00, 1'b0, k, so, sf, sz);
      tick(1'b0, so, sf, sz, g);
      expect_cycle(6'h2b, 6'h00, 1'b0, k, e, care);
      n_cmp++;
      if (mask(g, care) !== mask(e, care)) begin
        n_bad++;
        $display("FAIL abort_pre k=%0d got=%h want=%h", k, g, e);
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick(1'b1, 6'h2b, 6'($urandom), 1'b1, g);
      e = reset_obs();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL abort_reset hold=%0d cyc=%0d got=%h want=%h (memwrite=%0d pcen=%0d)",
                 hold, h, g, e, g.memwrite, g.pcen);
      end
    end
    for (int k = 0; k < 5; k++) begin
      stim(6'h23, 6'h00, 1'b0, k, so, sf, sz);
      tick(1'b0, so, sf, sz, g);
      expect_cycle(6'h23, 6'h00, 1'b0, k, e, care);
      n_cmp++;
      if (mask(g, care) !== mask(e, care)) begin
        n_bad++;
        $display("FAIL abort_post hold=%0d k=%0d got=%h want=%h", hold, k, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid(1);
    test_reset_mid(2);
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
